// File: rtl/uart.sv
// 8N1 UART with an independent transmitter and receiver on a single clock.
// CLKS_PER_BIT sets the bit period; the receiver samples each bit at its midpoint.
module uart #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rxd,
  output logic       txd,
  input  logic       txce,
  input  logic [7:0] tx,
  output logic       rxce,
  output logic [7:0] rx,
  output logic       bsy,
  output logic       transmit,
  output logic       frmero
);

  localparam int CW = 16;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // ---------------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------------
  state_t          tx_state, tx_state_n;
  logic [CW-1:0]   tx_cnt, tx_cnt_n;
  logic [2:0]      tx_bit, tx_bit_n;
  logic [7:0]      tx_shift, tx_shift_n;
  logic            txce_q;
  logic            txd_n, bsy_n, transmit_n;
  logic            txce_rise;

  assign txce_rise = txce & ~txce_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      txce_q   <= 1'b0;
      txd      <= 1'b1;
      bsy      <= 1'b0;
      transmit <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shift <= tx_shift_n;
      txce_q   <= txce;
      txd      <= txd_n;
      bsy      <= bsy_n;
      transmit <= transmit_n;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shift_n = tx_shift;
    txd_n      = txd;
    bsy_n      = bsy;
    transmit_n = 1'b0;

    unique case (tx_state)
      IDLE: begin
        txd_n = 1'b1;
        bsy_n = 1'b0;
        if (txce_rise) begin
          tx_state_n = START;
          tx_shift_n = tx;
          tx_cnt_n   = '0;
          txd_n      = 1'b0;
          bsy_n      = 1'b1;
        end
      end

      START: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = DATA;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (tx_cnt == BIT_LAST) begin
          tx_cnt_n = '0;
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            txd_n      = 1'b1;
          end else begin
            // Shift right so the next bit to send always sits in position 0.
            tx_bit_n   = tx_bit + 3'd1;
            tx_shift_n = {1'b0, tx_shift[7:1]};
            txd_n      = tx_shift[1];
          end
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end

      STOP: begin
        if (tx_cnt == BIT_LAST) begin
          tx_state_n = IDLE;
          tx_cnt_n   = '0;
          bsy_n      = 1'b0;
          transmit_n = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt + CNT_ONE;
        end
      end

      default: tx_state_n = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------------
  logic            rx_meta, rx_sync, rx_prev;
  state_t          rx_state, rx_state_n;
  logic [CW-1:0]   rx_cnt, rx_cnt_n;
  logic [2:0]      rx_bit, rx_bit_n;
  logic [7:0]      rx_shift, rx_shift_n;
  logic [7:0]      rx_n;
  logic            rxce_n, frmero_n;
  logic            start_edge;

  // Line flops reset to the idle level so reset release never looks like a start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A falling edge is needed, so a line stuck low after a framing error
  // cannot start a new frame until it has returned high.
  assign start_edge = rx_prev & ~rx_sync;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
      rx       <= '0;
      rxce     <= 1'b0;
      frmero   <= 1'b0;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
      rx       <= rx_n;
      rxce     <= rxce_n;
      frmero   <= frmero_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    rx_n       = rx;
    rxce_n     = 1'b0;
    frmero_n   = frmero;

    unique case (rx_state)
      IDLE: begin
        if (start_edge) begin
          rx_state_n = START;
          rx_cnt_n   = '0;
          frmero_n   = 1'b0;
        end
      end

      START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n = '0;
          if (rx_sync) begin
            rx_state_n = IDLE;
          end else begin
            rx_state_n = DATA;
            rx_bit_n   = '0;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end

      DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_sync, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end

      STOP: begin
        // Decide at the stop-bit midpoint and go straight back to IDLE so a
        // back-to-back start bit is not missed.
        if (rx_cnt == BIT_LAST) begin
          rx_state_n = IDLE;
          rx_cnt_n   = '0;
          if (rx_sync) begin
            rx_n   = rx_shift;
            rxce_n = 1'b1;
          end else begin
            frmero_n = 1'b1;
          end
        end else begin
          rx_cnt_n = rx_cnt + CNT_ONE;
        end
      end

      default: rx_state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart.sv
// Self-checking bench for uart: randomized 8N1 frames checked against a
// frame-level model of the serial line and the receive register.
`timescale 1ns/1ps
module tb_uart;

  localparam int CPB = 16;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic       rxd_drv = 1'b1;
  logic       loop    = 1'b0;
  logic       txce    = 1'b0;
  logic [7:0] tx      = 8'h00;
  logic       rxd_line;
  logic       txd, rxce, bsy, transmit, frmero;
  logic [7:0] rx;

  int checks = 0;
  int passes = 0;
  int cycle  = 0;
  int rxce_count = 0;
  int tx_pulse_count = 0;
  int last_rxce_cycle = 0;
  logic [7:0] last_rxce_val = 8'h00;
  logic [7:0] model_rx = 8'h00;

  assign rxd_line = loop ? txd : rxd_drv;

  uart #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .rxd(rxd_line), .txd(txd), .txce(txce),
    .tx(tx), .rxce(rxce), .rx(rx), .bsy(bsy), .transmit(transmit), .frmero(frmero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle++;

  always @(negedge clock) begin
    if (rxce) begin
      rxce_count++;
      last_rxce_cycle = cycle;
      last_rxce_val   = rx;
    end
    if (transmit) tx_pulse_count++;
  end

  // Drive one 8N1 frame on rxd; the start bit may already be partly driven.
  task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int start_cycles);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd_drv = frame[i];
      repeat (i == 0 ? start_cycles : CPB) @(negedge clock);
    end
    rxd_drv = 1'b1;
  endtask

  task automatic rx_frame_and_check(input logic [7:0] b, input int start_cycles, input string name);
    int c0, start, lat;
    c0    = rxce_count;
    start = cycle - (CPB - start_cycles);
    drive_frame(b, 1'b1, start_cycles);
    checks++; if (rxce_count !== c0 + 1) $display("FAIL %s_rxce_count: got %0d want %0d", name, rxce_count - c0, 1); else passes++;
    checks++; if (last_rxce_val !== b) $display("FAIL %s_rx_at_pulse: got %h want %h", name, last_rxce_val, b); else passes++;
    checks++; if (rx !== b) $display("FAIL %s_rx: got %h want %h", name, rx, b); else passes++;
    checks++; if (frmero !== 1'b0) $display("FAIL %s_frmero: got %b want 0", name, frmero); else passes++;
    lat = last_rxce_cycle - start;
    checks++;
    if (lat < 9 * CPB + CPB / 2 - 4 || lat > 9 * CPB + CPB / 2 + 6)
      $display("FAIL %s_latency: got %0d cycles want about %0d", name, lat, 9 * CPB + CPB / 2);
    else passes++;
    model_rx = b;
  endtask

  // Send one byte and check the line bit by bit at each bit midpoint.
  task automatic send_and_check_tx(input logic [7:0] b, input int retrig_at, input bit keep_high, input string name);
    logic [9:0] exp_bits;
    int guard, n, busy;
    exp_bits = {1'b1, b, 1'b0};
    guard = 0;
    while (bsy === 1'b1 && guard < 20 * CPB) begin @(negedge clock); guard++; end
    if (guard == 20 * CPB) begin
      checks++; $display("FAIL %s_idle_wait: bsy=%b still high after %0d cycles", name, bsy, guard);
    end
    txce = 1'b0;
    @(negedge clock);
    tx   = b;
    txce = 1'b1;
    @(negedge clock);
    checks++; if (bsy !== 1'b1) $display("FAIL %s_bsy_rise: got %b want 1", name, bsy); else passes++;
    n = 0; busy = 0;
    while (bsy === 1'b1 && n < 12 * CPB) begin
      n++; busy++;
      if ((n - 1) % CPB == CPB / 2 - 1 && (n - 1) / CPB < 10) begin
        checks++;
        if (txd !== exp_bits[(n - 1) / CPB])
          $display("FAIL %s_txd_bit%0d: got %b want %b", name, (n - 1) / CPB, txd, exp_bits[(n - 1) / CPB]);
        else passes++;
      end
      if (retrig_at != 0 && n == retrig_at) txce = 1'b0;
      if (retrig_at != 0 && n == retrig_at + 1) begin tx = ~b; txce = 1'b1; end
      @(negedge clock);
    end
    checks++; if (busy !== 10 * CPB) $display("FAIL %s_bsy_len: got %0d want %0d", name, busy, 10 * CPB); else passes++;
    checks++; if (transmit !== 1'b1) $display("FAIL %s_transmit_at_end: got %b want 1", name, transmit); else passes++;
    if (!keep_high) txce = 1'b0;
  endtask

  task automatic test_reset();
    int c0, guard;
    #1 reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd); else passes++;
    checks++; if (bsy !== 1'b0) $display("FAIL reset_bsy: got %b want 0", bsy); else passes++;
    checks++; if (transmit !== 1'b0) $display("FAIL reset_transmit: got %b want 0", transmit); else passes++;
    checks++; if (rxce !== 1'b0) $display("FAIL reset_rxce: got %b want 0", rxce); else passes++;
    checks++; if (rx !== 8'h00) $display("FAIL reset_rx: got %h want 00", rx); else passes++;
    checks++; if (frmero !== 1'b0) $display("FAIL reset_frmero: got %b want 0", frmero); else passes++;
    reset = 1'b1;
    repeat (4) @(negedge clock);
    checks++; if (bsy !== 1'b0 || txd !== 1'b1) $display("FAIL reset_idle_after_release: bsy=%b txd=%b want 0/1", bsy, txd); else passes++;
    // txce already high at release counts as a rising edge.
    c0 = tx_pulse_count;
    reset = 1'b0;
    txce  = 1'b1;
    tx    = 8'h00;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (bsy !== 1'b1 || txd !== 1'b0) $display("FAIL reset_txce_high_release: bsy=%b txd=%b want 1/0", bsy, txd); else passes++;
    guard = 0;
    while (bsy === 1'b1 && guard < 12 * CPB) begin @(negedge clock); guard++; end
    txce = 1'b0;
    repeat (2) @(negedge clock);
    checks++; if (tx_pulse_count !== c0 + 1) $display("FAIL reset_release_frame_pulse: got %0d want 1", tx_pulse_count - c0); else passes++;
  endtask

  task automatic test_tx();
    int c0;
    c0 = tx_pulse_count;
    send_and_check_tx(8'hA7, 0, 1'b0, "tx_a7");
    repeat (3) @(negedge clock);
    checks++; if (tx_pulse_count !== c0 + 1) $display("FAIL tx_a7_pulse_count: got %0d want 1", tx_pulse_count - c0); else passes++;
    checks++; if (txd !== 1'b1 || bsy !== 1'b0) $display("FAIL tx_a7_idle: txd=%b bsy=%b want 1/0", txd, bsy); else passes++;
  endtask

  task automatic test_rx();
    repeat (CPB) @(negedge clock);
    rx_frame_and_check(8'h55, CPB, "rx_55");
  endtask

  task automatic test_frame_error();
    int c0;
    c0 = rxce_count;
    repeat (2 * CPB) @(negedge clock);
    drive_frame(8'h3C, 1'b0, CPB);
    repeat (4) @(negedge clock);
    checks++; if (frmero !== 1'b1) $display("FAIL ferr_flag: got %b want 1", frmero); else passes++;
    checks++; if (rxce_count !== c0) $display("FAIL ferr_no_rxce: got %0d pulses want 0", rxce_count - c0); else passes++;
    checks++; if (rx !== model_rx) $display("FAIL ferr_rx_hold: got %h want %h", rx, model_rx); else passes++;
    repeat (2 * CPB) @(negedge clock);
    checks++; if (frmero !== 1'b1) $display("FAIL ferr_flag_sticky: got %b want 1", frmero); else passes++;
    rxd_drv = 1'b0;
    repeat (5) @(negedge clock);
    checks++; if (frmero !== 1'b0) $display("FAIL ferr_clear_at_start: got %b want 0", frmero); else passes++;
    rx_frame_and_check(8'h81, CPB - 5, "ferr_next_81");
  endtask

  task automatic test_false_start();
    int c0;
    c0 = rxce_count;
    repeat (CPB) @(negedge clock);
    rxd_drv = 1'b0;
    repeat (3) @(negedge clock);
    rxd_drv = 1'b1;
    repeat (2 * CPB) @(negedge clock);
    checks++; if (rxce_count !== c0) $display("FAIL false_start_rxce: got %0d pulses want 0", rxce_count - c0); else passes++;
    checks++; if (rx !== model_rx) $display("FAIL false_start_rx: got %h want %h", rx, model_rx); else passes++;
    checks++; if (frmero !== 1'b0) $display("FAIL false_start_frmero: got %b want 0", frmero); else passes++;
    rx_frame_and_check(8'($urandom_range(1, 255)), CPB, "false_start_next");
  endtask

  task automatic test_busy_hold();
    int c0, busy_seen;
    c0 = tx_pulse_count;
    send_and_check_tx(8'h3C, 3 * CPB, 1'b1, "busy_hold");
    busy_seen = 0;
    repeat (3 * CPB) begin
      @(negedge clock);
      if (bsy === 1'b1) busy_seen++;
    end
    checks++; if (busy_seen !== 0) $display("FAIL busy_hold_no_retrigger: bsy high %0d cycles want 0", busy_seen); else passes++;
    checks++; if (tx_pulse_count !== c0 + 1) $display("FAIL busy_hold_one_frame: got %0d pulses want 1", tx_pulse_count - c0); else passes++;
    txce = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_loopback();
    int c0;
    c0 = rxce_count;
    loop = 1'b1;
    send_and_check_tx(8'hA7, 0, 1'b0, "loop_a7");
    repeat (4) @(negedge clock);
    checks++; if (rxce_count !== c0 + 1) $display("FAIL loop_rxce_count: got %0d want 1", rxce_count - c0); else passes++;
    checks++; if (rx !== 8'hA7) $display("FAIL loop_rx: got %h want a7", rx); else passes++;
    loop = 1'b0;
    model_rx = 8'hA7;
  endtask

  task automatic test_reset_mid_frame();
    int c_rx, c_tx;
    c_rx = rxce_count;
    c_tx = tx_pulse_count;
    txce = 1'b0;
    @(negedge clock);
    tx      = 8'h00;
    txce    = 1'b1;
    rxd_drv = 1'b0;
    repeat (3 * CPB + 5) @(negedge clock);
    checks++; if (txd !== 1'b0 || bsy !== 1'b1) $display("FAIL midreset_pre: txd=%b bsy=%b want 0/1", txd, bsy); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) $display("FAIL midreset_txd: got %b want 1", txd); else passes++;
    checks++; if (bsy !== 1'b0) $display("FAIL midreset_bsy: got %b want 0", bsy); else passes++;
    checks++; if (rx !== 8'h00) $display("FAIL midreset_rx: got %h want 00", rx); else passes++;
    rxd_drv = 1'b1;
    txce    = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    model_rx = 8'h00;
    repeat (12 * CPB) @(negedge clock);
    checks++; if (rxce_count !== c_rx) $display("FAIL midreset_no_rxce: got %0d pulses want 0", rxce_count - c_rx); else passes++;
    checks++; if (tx_pulse_count !== c_tx) $display("FAIL midreset_no_transmit: got %0d pulses want 0", tx_pulse_count - c_tx); else passes++;
    send_and_check_tx(8'($urandom_range(0, 255)), 0, 1'b0, "midreset_next_tx");
    rx_frame_and_check(8'($urandom_range(0, 255)), CPB, "midreset_next_rx");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) rx_frame_and_check(8'($urandom_range(0, 255)), CPB, "b2b");
  endtask

  task automatic test_simultaneous();
    logic [7:0] b1, b2;
    for (int i = 0; i < 3; i++) begin
      b1 = 8'($urandom_range(0, 255));
      b2 = 8'($urandom_range(0, 255));
      fork
        send_and_check_tx(b1, 0, 1'b0, "sim_tx");
        rx_frame_and_check(b2, CPB, "sim_rx");
      join
      repeat (CPB) @(negedge clock);
    end
  endtask

  initial begin
    test_reset();
    test_tx();
    test_rx();
    test_frame_error();
    test_false_start();
    test_busy_hold();
    test_loopback();
    test_reset_mid_frame();
    test_back_to_back();
    test_simultaneous();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
